pangya_cursor: RTL and testbench

//  Timing-minigame cursor that runs alongside the power-bar overlay (bar spans x 221..379, y 301..305).
//  - Green zone x 291..309; yellow 261..290 / 310..339; red 221..260 / 340..379.
//  - Sweeps a cursor back and forth across the bar once per video frame.
//  - Latches the zone under the cursor on a player hit and reports the result.
//  - Produces a registered cursor pixel overlay for the downstream colour mux, which places it above the bar.

---
 rtl/pangya_cursor.sv | 144 ++++++++++++++
 tb/tb_pangya_cursor.sv | 174 +++++++++++++++++
 2 files changed

// File: rtl/pangya_cursor.sv
// pangya_cursor: power-bar timing cursor; sweeps once per frame tick, latches the zone on a hit, draws an overlay
module pangya_cursor #(
  parameter int LEFT        = 221,
  parameter int RIGHT       = 379,
  parameter int SPEED       = 2,
  parameter int TICK_LINE   = 481,
  parameter int MAX_PASSES  = 4,
  parameter int HOLD_FRAMES = 60
) (
  input  logic        Pclk,
  input  logic        rst_n,
  input  logic [9:0]  xx,
  input  logic [9:0]  yy,
  input  logic        aactive,
  input  logic        start,
  input  logic        hit,
  output logic        cursorOn,
  output logic [11:0] cursor_color,
  output logic [9:0]  cursor_x,
  output logic [1:0]  result,
  output logic        result_valid,
  output logic        busy
);
  localparam int PW = $clog2(MAX_PASSES + 1);
  localparam int HW = $clog2(HOLD_FRAMES + 1);

  typedef enum logic [1:0] {IDLE, SWEEP, HOLD} state_t;

  state_t        state, state_n;
  logic          tick, h1, h2, h3, hit_edge;
  logic          dir, dir_n;
  logic [PW-1:0] passes, passes_n;
  logic [HW-1:0] hold_cnt, hold_n;
  logic [9:0]    cx_n;
  logic [1:0]    res_n, zone;
  logic          rv_n, on;
  logic [10:0]   up, dn;

  assign hit_edge = h2 & ~h3;
  assign busy     = state != IDLE;
  assign up       = {1'b0, cursor_x} + 11'(SPEED);
  assign dn       = {1'b0, cursor_x} - 11'(SPEED);
  assign zone     = (cursor_x >= 10'd291 && cursor_x <= 10'd309) ? 2'd3 :
                    (cursor_x >= 10'd261 && cursor_x <= 10'd339) ? 2'd2 :
                    (cursor_x >= 10'd221 && cursor_x <= 10'd379) ? 2'd1 : 2'd0;
  assign on       = aactive && state != IDLE &&
                    ({1'b0, xx} + 11'd1 >= {1'b0, cursor_x}) &&
                    ({1'b0, xx} <= {1'b0, cursor_x} + 11'd1) &&
                    yy >= 10'd296 && yy <= 10'd310;

  // frame tick and hit synchronizer with rising-edge history
  always_ff @(posedge Pclk or negedge rst_n) begin
    if (!rst_n) begin
      tick <= 1'b0;
      h1   <= 1'b0;
      h2   <= 1'b0;
      h3   <= 1'b0;
    end else begin
      tick <= xx == 10'd0 && yy == 10'(TICK_LINE);
      h1   <= hit;
      h2   <= h1;
      h3   <= h2;
    end
  end

  // FSM and cursor state registers
  always_ff @(posedge Pclk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      cursor_x     <= 10'(LEFT);
      dir          <= 1'b0;
      passes       <= '0;
      hold_cnt     <= '0;
      result       <= 2'd0;
      result_valid <= 1'b0;
    end else begin
      state        <= state_n;
      cursor_x     <= cx_n;
      dir          <= dir_n;
      passes       <= passes_n;
      hold_cnt     <= hold_n;
      result       <= res_n;
      result_valid <= rv_n;
    end
  end

  // next state: sweep stepping with end clamping, hit/miss capture, hold countdown
  always_comb begin
    state_n  = state;
    cx_n     = cursor_x;
    dir_n    = dir;
    passes_n = passes;
    hold_n   = hold_cnt;
    res_n    = result;
    rv_n     = 1'b0;
    case (state)
      IDLE: begin
        cx_n = 10'(LEFT);
        if (start) begin
          state_n  = SWEEP;
          dir_n    = 1'b0;
          passes_n = '0;
        end
      end
      SWEEP: begin
        if (hit_edge || passes == PW'(MAX_PASSES)) begin
          res_n   = hit_edge ? zone : 2'd0;
          rv_n    = 1'b1;
          state_n = HOLD;
          hold_n  = '0;
        end else if (tick && !dir) begin
          cx_n     = (up >= 11'(RIGHT)) ? 10'(RIGHT) : up[9:0];
          dir_n    = up >= 11'(RIGHT);
          passes_n = (up >= 11'(RIGHT)) ? passes + 1'b1 : passes;
        end else if (tick) begin
          cx_n     = ({1'b0, cursor_x} <= 11'(LEFT + SPEED)) ? 10'(LEFT) : dn[9:0];
          dir_n    = !({1'b0, cursor_x} <= 11'(LEFT + SPEED));
          passes_n = ({1'b0, cursor_x} <= 11'(LEFT + SPEED)) ? passes + 1'b1 : passes;
        end
      end
      HOLD: begin
        if (tick && hold_cnt == HW'(HOLD_FRAMES - 1)) begin
          state_n = IDLE;
          cx_n    = 10'(LEFT);
          hold_n  = '0;
        end else if (tick) begin
          hold_n = hold_cnt + 1'b1;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // registered overlay, one cycle behind the pixel coordinates like the bar
  always_ff @(posedge Pclk or negedge rst_n) begin
    if (!rst_n) begin
      cursorOn     <= 1'b0;
      cursor_color <= 12'h000;
    end else begin
      cursorOn     <= on;
      cursor_color <= on ? ((state == SWEEP) ? 12'hFFF : 12'h00F) : 12'h000;
    end
  end
endmodule

// File: tb/tb_pangya_cursor.sv
// tb_pangya_cursor: randomized scenarios against a triangle-wave position model and zone table
module tb_pangya_cursor;
  localparam int LEFT = 221, RIGHT = 379, SPEED = 2, HOLD_FRAMES = 60;

  logic        Pclk = 0, rst_n = 0;
  logic [9:0]  xx = 10'd5, yy = 10'd0;
  logic        aactive = 0, start = 0, hit = 0;
  logic        cursorOn, result_valid, busy;
  logic [11:0] cursor_color;
  logic [9:0]  cursor_x;
  logic [1:0]  result;
  int          checks = 0, failures = 0;

  pangya_cursor dut (
    .Pclk(Pclk), .rst_n(rst_n), .xx(xx), .yy(yy), .aactive(aactive),
    .start(start), .hit(hit), .cursorOn(cursorOn), .cursor_color(cursor_color),
    .cursor_x(cursor_x), .result(result), .result_valid(result_valid), .busy(busy)
  );

  always #5 Pclk = ~Pclk;

  function automatic int model_pos(int k);
    int n = (RIGHT - LEFT) / SPEED;
    int m = k % (2 * n);
    return (m <= n) ? LEFT + SPEED * m : RIGHT - SPEED * (m - n);
  endfunction

  function automatic int model_zone(int x);
    if (x >= 291 && x <= 309) return 3;
    if (x >= 261 && x <= 339) return 2;
    if (x >= 221 && x <= 379) return 1;
    return 0;
  endfunction

  task automatic ticks(int n);
    for (int i = 0; i < n; i++) begin
      @(negedge Pclk); xx = 10'd0; yy = 10'd481;
      @(negedge Pclk); xx = 10'd5; yy = 10'd0;
    end
    @(negedge Pclk);
  endtask

  task automatic do_reset();
    @(negedge Pclk); rst_n = 0; aactive = 0; hit = 0; start = 0;
    #2 rst_n = 1;
    @(negedge Pclk);
  endtask

  task automatic do_start();
    @(negedge Pclk); start = 1;
    @(negedge Pclk); start = 0;
  endtask

  task automatic test_reset();
    int pulses;
    do_reset();
    checks++; if (cursor_x !== 10'd221 || busy !== 0 || cursorOn !== 0 || result !== 0 || result_valid !== 0 || cursor_color !== 0) begin
      failures++; $display("FAIL reset_init: x=%0d busy=%b on=%b res=%0d rv=%b col=%h, want 221/0/0/0/0/000", cursor_x, busy, cursorOn, result, result_valid, cursor_color); end
    do_start(); ticks(35);
    hit = 1; pulses = 0;
    for (int c = 0; c < 8; c++) begin @(negedge Pclk); if (c == 3) hit = 0; if (result_valid) pulses++; end
    ticks(HOLD_FRAMES);
    checks++; if (busy !== 0 || cursor_x !== 10'd221 || result !== 2'd3 || pulses != 1) begin
      failures++; $display("FAIL reset_prep: busy=%b x=%0d res=%0d pulses=%0d, want 0/221/3/1", busy, cursor_x, result, pulses); end
    do_start(); ticks(40);
    checks++; if (cursor_x !== 10'd301 || busy !== 1) begin
      failures++; $display("FAIL reset_midsweep_pos: x=%0d busy=%b, want 301/1", cursor_x, busy); end
    #1 rst_n = 0;
    #1;
    checks++; if (cursor_x !== 10'd221 || busy !== 0 || cursorOn !== 0 || result !== 0) begin
      failures++; $display("FAIL reset_async: x=%0d busy=%b on=%b res=%0d, want 221/0/0/0", cursor_x, busy, cursorOn, result); end
    @(negedge Pclk); rst_n = 1;
    @(negedge Pclk);
  endtask

  task automatic test_zones();
    int ks[$] = '{35, 20, 10};
    for (int t = 0; t < 6; t++) ks.push_back($urandom_range(0, 315));
    foreach (ks[i]) begin
      int k = ks[i], pulses = 0, got = -1, exp_x = model_pos(ks[i]);
      do_reset(); do_start(); ticks(k);
      checks++; if (cursor_x !== 10'(exp_x)) begin
        failures++; $display("FAIL sweep_pos k=%0d: x=%0d, want %0d", k, cursor_x, exp_x); end
      hit = 1;
      for (int c = 0; c < 8; c++) begin
        @(negedge Pclk); if (c == 3) hit = 0;
        if (result_valid) begin pulses++; got = result; end
      end
      checks++; if (pulses != 1 || got != model_zone(exp_x) || busy !== 1 || result !== 2'(model_zone(exp_x))) begin
        failures++; $display("FAIL hit_zone k=%0d x=%0d: pulses=%0d res=%0d busy=%b, want 1/%0d/1", k, exp_x, pulses, got, busy, model_zone(exp_x)); end
      xx = 10'(exp_x); yy = 10'd300; aactive = 1;
      @(negedge Pclk);
      checks++; if (cursorOn !== 1 || cursor_color !== 12'h00F || cursor_x !== 10'(exp_x)) begin
        failures++; $display("FAIL hold_overlay k=%0d: on=%b col=%h x=%0d, want 1/00F/%0d", k, cursorOn, cursor_color, cursor_x, exp_x); end
      aactive = 0; xx = 10'd5; yy = 10'd0;
    end
  endtask

  task automatic test_bounce();
    do_reset(); do_start(); ticks(40);
    do_start();
    checks++; if (cursor_x !== 10'd301 || busy !== 1) begin
      failures++; $display("FAIL start_ignored: x=%0d busy=%b, want 301/1", cursor_x, busy); end
    ticks(39);
    checks++; if (cursor_x !== 10'd379) begin failures++; $display("FAIL bounce_right: x=%0d, want 379", cursor_x); end
    ticks(1);
    checks++; if (cursor_x !== 10'd377) begin failures++; $display("FAIL after_bounce: x=%0d, want 377", cursor_x); end
    ticks(78);
    checks++; if (cursor_x !== 10'd221 || busy !== 1) begin
      failures++; $display("FAIL bounce_left: x=%0d busy=%b, want 221/1", cursor_x, busy); end
    ticks(1);
    checks++; if (cursor_x !== 10'(model_pos(159))) begin
      failures++; $display("FAIL second_lap: x=%0d, want %0d", cursor_x, model_pos(159)); end
  endtask

  task automatic test_miss();
    int pulses = 0, got = -1, late = 0;
    do_reset(); do_start(); ticks(315);
    checks++; if (busy !== 1 || result_valid !== 0) begin
      failures++; $display("FAIL pre_miss: busy=%b rv=%b, want 1/0", busy, result_valid); end
    ticks(1);
    for (int c = 0; c < 4; c++) begin
      if (result_valid) begin pulses++; got = result; end
      @(negedge Pclk);
    end
    checks++; if (pulses != 1 || got != 0 || busy !== 1 || cursor_x !== 10'd221) begin
      failures++; $display("FAIL miss: pulses=%0d res=%0d busy=%b x=%0d, want 1/0/1/221", pulses, got, busy, cursor_x); end
    hit = 1;
    for (int c = 0; c < 8; c++) begin @(negedge Pclk); if (c == 3) hit = 0; if (result_valid) late++; end
    checks++; if (late != 0 || result !== 0) begin
      failures++; $display("FAIL hold_hit_ignored: pulses=%0d res=%0d, want 0/0", late, result); end
    ticks(HOLD_FRAMES - 1);
    checks++; if (busy !== 1) begin failures++; $display("FAIL hold_len: busy=%b, want 1", busy); end
    ticks(1);
    checks++; if (busy !== 0 || cursor_x !== 10'd221) begin
      failures++; $display("FAIL hold_exit: busy=%b x=%0d, want 0/221", busy, cursor_x); end
  endtask

  task automatic test_overlay();
    do_reset(); do_start(); ticks(35);
    xx = 10'd292; yy = 10'd298; aactive = 1;
    @(negedge Pclk);
    checks++; if (cursorOn !== 1 || cursor_color !== 12'hFFF) begin
      failures++; $display("FAIL overlay_on: on=%b col=%h, want 1/FFF", cursorOn, cursor_color); end
    xx = 10'd293;
    @(negedge Pclk);
    checks++; if (cursorOn !== 0 || cursor_color !== 12'h000) begin
      failures++; $display("FAIL overlay_off: on=%b col=%h, want 0/000", cursorOn, cursor_color); end
    for (int i = 0; i < 20; i++) begin
      int x = $urandom_range(285, 297), y = $urandom_range(290, 315), a = $urandom_range(0, 1);
      logic e;
      xx = 10'(x); yy = 10'(y); aactive = a[0];
      e = a == 1 && x >= 290 && x <= 292 && y >= 296 && y <= 310;
      @(negedge Pclk);
      checks++; if (cursorOn !== e || cursor_color !== (e ? 12'hFFF : 12'h000)) begin
        failures++; $display("FAIL overlay_rand x=%0d y=%0d a=%0d: on=%b col=%h, want %b", x, y, a, cursorOn, cursor_color, e); end
    end
    do_reset();
    xx = 10'd221; yy = 10'd300; aactive = 1;
    @(negedge Pclk);
    checks++; if (cursorOn !== 0) begin failures++; $display("FAIL overlay_idle: on=%b, want 0", cursorOn); end
    aactive = 0;
  endtask

  initial begin
    test_reset();
    test_zones();
    test_bounce();
    test_miss();
    test_overlay();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
